qei_multi: RTL and testbench
============================

# qei_multi

Parametrised multi-channel quadrature encoder interface for the wheel odometry path. Each channel has input synchronisation, a glitch filter, x4 decoding, a wrapping position counter and a per-period signed velocity measurement. Velocity samples from all channels are published together with a one-cycle strobe for the PID stage. Illegal (double-step) transitions are flagged per channel.

## Interface
- NCH, 2: number of encoder channels (≥1)
- NBITS, 16: position counter width per channel
- VBITS, 12: signed velocity width per channel (≤ NBITS)
- PERIOD, 48000: velocity sample period in clk cycles (≥ 2); 1 kHz at 48 MHz
- FILT, 3: cycles an input pair must be stable before acceptance (≥ 1)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clr  in  1  synchronous clear of positions, accumulators, velocities and prescaler
- en  in  1  counting enable
- err_clr  in  1  clears all sticky error flags
- in_A  in  NCH  encoder A inputs, asynchronous, bit i = channel i
- in_B  in  NCH  encoder B inputs, asynchronous
- pos  out  NCH*NBITS  position counters, channel i at [i*NBITS +: NBITS], unsigned, wrapping
- vel  out  NCH*VBITS  signed two's-complement counts per period, channel i at [i*VBITS +: VBITS]
- vel_valid  out  1  one-cycle strobe: vel updated this cycle
- err  out  NCH  sticky illegal-transition flags

## Operation
- Sync: two flip-flop stages per A and B bit; no logic between stages.
- Filter: per channel, a candidate {A,B} from sync stage 2 plus a stability counter. If the candidate equals the previous sync value, the counter increments and saturates at FILT. Otherwise the counter reloads to 1. When the counter reaches FILT, the candidate becomes the filtered state.
- Priming: after rst, each channel's first accepted filtered state is loaded with no step and no error. A per-channel primed flag is set.
- Decode (primed channels only), comparing old and new filtered states:
  - Forward sequence 00→01→11→10→00 gives +1.
  - Reverse sequence gives −1.
  - No change gives 0.
  - Both bits changing gives 0 and sets err[i].
- en=0: steps are discarded and the prescaler holds. Filter and filtered state keep tracking, so re-enabling produces no spurious step. err still sets.
- Position: pos_i += step, modulo 2^NBITS (wraps both directions).
- Velocity: acc_i is a signed VBITS accumulator that adds step and saturates at +(2^(VBITS−1)−1) and −(2^(VBITS−1)−1).
- Prescaler: counts 0..PERIOD−1. On the cycle where it equals PERIOD−1 with en=1 (the tick):
  - vel_i ← acc_i + step_i of the same cycle, saturated.
  - acc_i ← 0.
  - prescaler ← 0.
- Priority: rst > clr > normal operation.
  - clr zeros pos, acc, vel and the prescaler, and suppresses vel_valid.
  - clr keeps filter state, primed flags and err.
- err: set has priority over err_clr in the same cycle.

## Timing
- Reset values: pos=0, vel=0, vel_valid=0, err=0, prescaler=0, primed=0, filter counters=0.
- Step latency: an input level first sampled at edge k that stays stable is reflected in pos after edge k+FILT+2.
  - 2 sync stages, then FILT−1 further edges of filter stability, then 1 edge for decode and count.
- vel and vel_valid are registered together. vel_valid is high for exactly one cycle, on the cycle after the tick edge.
- With en=1 continuously, vel_valid pulses every PERIOD cycles. The first pulse comes PERIOD cycles after rst or clr is released.
- Pulses of any input shorter than FILT cycles (post-sync) produce no step.
- Reset mid-count: all state returns to reset values on the next edge, and channels re-prime.
- Counter wrap: 0 with −1 gives 2^NBITS−1, and vice versa; err is not set.

## Test plan
- Priming: rst, then hold A=B=1 on channel 0. Required: pos0 stays 0, err=0.
- Forward/reverse: NCH=2, FILT=3; drive ch0 forward 10 steps, then ch1 reverse 5 steps, each step held 8 cycles. Required: pos0=10, pos1=0xFFFB, err=0; each step lands FILT+2 edges after the change.
- Glitch: a 2-cycle pulse on A0 with FILT=3. Required: pos0 unchanged. A 3-cycle pulse must yield +1 then −1.
- Velocity: PERIOD=100; 7 forward steps on ch0 and 3 reverse on ch1 within one period. Required: a single vel_valid pulse with vel0=7 and vel1=−3; the next period with no steps gives vel=0.
- Saturation/wrap: VBITS=4, 20 forward steps in one period. Required: vel0=+7. From pos0=0, one reverse step gives pos0=0xFFFF.
- Error/priority: change A0 and B0 together from 00 to 11. Required: err[0]=1, pos0 unchanged. Asserting err_clr on the same cycle as a new illegal transition keeps err[0]=1. clr then leaves err[0] set and zeros pos and vel.

Source files
------------

// File: rtl/qei_multi_if.sv
// qei_multi_if: control, encoder inputs and measurement outputs of qei_multi
interface qei_multi_if #(parameter int NCH = 2, parameter int NBITS = 16, parameter int VBITS = 12);
  logic clr, en, err_clr;
  logic [NCH-1:0] in_A, in_B, err;
  logic [NCH*NBITS-1:0] pos;
  logic [NCH*VBITS-1:0] vel;
  logic vel_valid;
  modport master(output clr, en, err_clr, in_A, in_B, input pos, vel, vel_valid, err);
  modport slave(input clr, en, err_clr, in_A, in_B, output pos, vel, vel_valid, err);
endinterface

// File: rtl/qei_multi.sv
// qei_multi: multi-channel x4 quadrature decoder with wrapping position and per-period velocity
module qei_multi #(
  parameter int NCH = 2,
  parameter int NBITS = 16,
  parameter int VBITS = 12,
  parameter int PERIOD = 48000,
  parameter int FILT = 3
) (
  input logic clk,
  input logic rst,
  qei_multi_if.slave bus
);
  localparam int CW = $clog2(FILT + 1);
  localparam int PW = $clog2(PERIOD);
  localparam logic signed [VBITS:0] VMAX = (VBITS + 1)'(2 ** (VBITS - 1) - 1);
  logic [PW-1:0] pre;
  logic tick, velValid;
  logic [NCH-1:0][NBITS-1:0] posArr;
  logic [NCH-1:0][VBITS-1:0] velArr;
  logic [NCH-1:0] errVec;
  assign tick = bus.en && pre == PW'(PERIOD - 1);
  assign bus.pos = posArr;
  assign bus.vel = velArr;
  assign bus.err = errVec;
  assign bus.vel_valid = velValid;
  always_ff @(posedge clk)
    if (rst || bus.clr) begin
      pre <= '0;
      velValid <= 1'b0;
    end else begin
      if (bus.en) pre <= tick ? '0 : pre + 1'b1;
      velValid <= tick;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0] s1, s2, cand, filt, oldIdx, newIdx, diff;
    logic [CW-1:0] cnt;
    logic primed, accept;
    logic signed [1:0] step;
    logic signed [VBITS-1:0] acc, vel;
    logic signed [VBITS:0] sum, sat;
    logic [NBITS-1:0] pos;
    logic errFlag;
    // Gray state {A,B} mapped to a 0..3 phase index so the step is a modular difference
    always_comb begin
      oldIdx = {filt[1], ^filt};
      newIdx = {cand[1], ^cand};
      diff = newIdx - oldIdx;
      accept = cnt == CW'(FILT) && primed;
      step = (accept && diff == 2'd1) ? 2'sd1 : (accept && diff == 2'd3) ? -2'sd1 : 2'sd0;
      sum = {acc[VBITS-1], acc} + {{(VBITS - 1){step[1]}}, step};
      sat = sum > VMAX ? VMAX : sum < -VMAX ? -VMAX : sum;
    end
    always_ff @(posedge clk)
      if (rst) begin
        s1 <= '0;
        s2 <= '0;
        cand <= '0;
        cnt <= '0;
        filt <= '0;
        primed <= 1'b0;
      end else begin
        s1 <= {bus.in_A[i], bus.in_B[i]};
        s2 <= s1;
        cand <= s2;
        cnt <= s2 != cand ? CW'(1) : cnt == CW'(FILT) ? cnt : cnt + 1'b1;
        if (cnt == CW'(FILT)) begin
          filt <= cand;
          primed <= 1'b1;
        end
      end
    always_ff @(posedge clk)
      if (rst || bus.clr) begin
        pos <= '0;
        acc <= '0;
        vel <= '0;
      end else begin
        if (bus.en) pos <= pos + NBITS'(step);
        acc <= tick ? '0 : bus.en ? sat[VBITS-1:0] : acc;
        if (tick) vel <= sat[VBITS-1:0];
      end
    // A fresh illegal transition wins over a simultaneous clear request
    always_ff @(posedge clk)
      if (rst) errFlag <= 1'b0;
      else errFlag <= (accept && diff == 2'd2) || (errFlag && !bus.err_clr);
    assign posArr[i] = pos;
    assign velArr[i] = vel;
    assign errVec[i] = errFlag;
  end
endmodule

// File: tb/tb_qei_multi.sv
// tb_qei_multi: directed vectors for position, filtering, velocity, saturation, wrap and error flags
module tb_qei_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  qei_multi_if #(.NCH(2), .NBITS(16), .VBITS(4)) bus();
  qei_multi #(.NCH(2), .NBITS(16), .VBITS(4), .PERIOD(100), .FILT(3)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [1:0] ab0, ab1;
    logic [15:0] p0, p1;
  } vec_t;
  vec_t tbl[15];
  logic [1:0] fseq[4];
  int nvec = 0;
  int nbad = 0;
  int i0, i1, n;
  task automatic cyc(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(logic [1:0] ab0, logic [1:0] ab1);
    bus.in_A = {ab1[1], ab0[1]};
    bus.in_B = {ab1[0], ab0[0]};
  endtask
  initial begin
    fseq[0] = 2'b00;
    fseq[1] = 2'b01;
    fseq[2] = 2'b11;
    fseq[3] = 2'b10;
    for (int k = 0; k < 10; k++) tbl[k] = '{fseq[(3 + k) % 4], 2'b00, 16'(k + 1), 16'd0};
    for (int k = 0; k < 5; k++) tbl[10 + k] = '{2'b00, fseq[(7 - k) % 4], 16'd10, 16'(-(k + 1))};
    bus.clr = 1'b0;
    bus.en = 1'b1;
    bus.err_clr = 1'b0;
    drive(2'b11, 2'b00);
    cyc(3);
    chk("reset_pos", bus.pos, 0);
    chk("reset_vel", bus.vel, 0);
    chk("reset_valid", bus.vel_valid, 0);
    chk("reset_err", bus.err, 0);
    rst = 1'b0;
    cyc(20);
    chk("prime_pos0", bus.pos[15:0], 0);
    chk("prime_err", bus.err, 0);
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].ab0, tbl[k].ab1);
      cyc(8);
      chk($sformatf("vec%0d_pos0", k), bus.pos[15:0], tbl[k].p0);
      chk($sformatf("vec%0d_pos1", k), bus.pos[31:16], tbl[k].p1);
      chk($sformatf("vec%0d_err", k), bus.err, 0);
    end
    i0 = 0;
    i1 = 3;
    i0 = 1;
    drive(fseq[i0], fseq[i1]);
    cyc(5);
    chk("latency_early", bus.pos[15:0], 10);
    cyc(1);
    chk("latency_land", bus.pos[15:0], 11);
    cyc(8);
    bus.in_A[0] = 1'b1;
    cyc(2);
    bus.in_A[0] = 1'b0;
    cyc(12);
    chk("glitch2_pos0", bus.pos[15:0], 11);
    bus.in_A[0] = 1'b1;
    cyc(3);
    bus.in_A[0] = 1'b0;
    cyc(3);
    chk("glitch3_up", bus.pos[15:0], 12);
    cyc(5);
    chk("glitch3_down", bus.pos[15:0], 11);
    chk("glitch3_err", bus.err, 0);
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    chk("clr_pos", bus.pos, 0);
    n = 0;
    for (int k = 0; k < 7; k++) begin
      i0 = (i0 + 1) % 4;
      if (k < 3) i1 = (i1 + 3) % 4;
      drive(fseq[i0], fseq[i1]);
      cyc(6);
      n += 6;
    end
    while (!bus.vel_valid && n < 300) begin
      cyc(1);
      n++;
    end
    chk("vel_first_pulse_cycle", n, 100);
    chk("vel0_fwd7", bus.vel[3:0], 4'd7);
    chk("vel1_rev3", bus.vel[7:4], 4'hD);
    cyc(1);
    chk("vel_valid_one_cycle", bus.vel_valid, 0);
    cyc(99);
    chk("vel_valid_second", bus.vel_valid, 1);
    chk("vel_idle", bus.vel, 0);
    for (int k = 0; k < 20; k++) begin
      i0 = (i0 + 1) % 4;
      drive(fseq[i0], fseq[i1]);
      cyc(4);
    end
    cyc(20);
    chk("vel_valid_third", bus.vel_valid, 1);
    chk("vel0_saturated", bus.vel[3:0], 4'd7);
    chk("pos0_after_27", bus.pos[15:0], 27);
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    i0 = 3;
    drive(fseq[i0], fseq[i1]);
    cyc(8);
    chk("wrap_down", bus.pos[15:0], 16'hFFFF);
    chk("wrap_err", bus.err, 0);
    i0 = 0;
    drive(fseq[i0], fseq[i1]);
    cyc(8);
    chk("wrap_up", bus.pos[15:0], 0);
    drive(2'b11, fseq[i1]);
    cyc(8);
    chk("illegal_err", bus.err, 2'b01);
    chk("illegal_pos0", bus.pos[15:0], 0);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    chk("err_clr", bus.err, 0);
    drive(2'b00, fseq[i1]);
    cyc(5);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    chk("err_set_beats_clr", bus.err, 2'b01);
    chk("illegal2_pos0", bus.pos[15:0], 0);
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    i0 = 1;
    drive(fseq[i0], fseq[i1]);
    n = 0;
    while (!bus.vel_valid && n < 150) begin
      cyc(1);
      n++;
    end
    chk("vel1_pulse_cycle", n, 100);
    chk("vel0_one", bus.vel[3:0], 4'd1);
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    chk("clr_pos0", bus.pos[15:0], 0);
    chk("clr_vel", bus.vel, 0);
    chk("clr_keeps_err", bus.err, 2'b01);
    chk("clr_valid", bus.vel_valid, 0);
    bus.en = 1'b0;
    i0 = 2;
    drive(fseq[i0], fseq[i1]);
    cyc(8);
    chk("en_off_pos0", bus.pos[15:0], 0);
    bus.en = 1'b1;
    cyc(8);
    chk("en_on_no_step", bus.pos[15:0], 0);
    i0 = 3;
    drive(fseq[i0], fseq[i1]);
    cyc(8);
    chk("en_on_step", bus.pos[15:0], 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_pos", bus.pos, 0);
    chk("midrst_err", bus.err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
